// File: rtl/shift_left_pc.sv
// shift_left_pc: MIPS J/JAL jump-target generator.
// The combinational target {pc[31:28], i, 2'b00} feeds the PC-select mux in
// the same cycle; an optional registered copy with a sticky valid flag serves
// pipelined or multi-cycle consumers.
module shift_left_pc (
   input  logic [25:0] i,
   input  logic [31:0] pc,
   output logic [31:0] out,
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   output logic [31:0] out_q,
   output logic        out_valid
);

   // Only the 256 MB region bits of the PC take part in the jump target;
   // the remaining PC bits are intentionally dropped.
   logic unused_pc_low;
   assign unused_pc_low = ^pc[27:0];

   // Pure wiring: the region bits stay on top, the word index sits below,
   // and the two byte-offset bits are zero. No adder, so no carry can leak
   // from the index into the region bits.
   always_comb begin
      out = {pc[31:28], i, 2'b00};
   end

   // Capture the target on load; valid stays set until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering between statements cannot matter.
      if (!rst_n) begin
         out_q     <= 32'h0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_q     <= out;
         out_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_left_pc.sv
// Self-checking bench for shift_left_pc: directed vector table, hand-written
// reset / hold sequences, and randomized traffic against a reference model.
module tb_shift_left_pc;

   logic [25:0] i;
   logic [31:0] pc;
   logic [31:0] out;
   logic        clk;
   logic        rst_n;
   logic        load;
   logic [31:0] out_q;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   // Expected state of the registered stage.
   logic [31:0] exp_q;
   logic        exp_valid;

   typedef struct {
      logic [25:0] idx;
      logic [31:0] pcv;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs[7];

   shift_left_pc dut (
      .i         (i),
      .pc        (pc),
      .out       (out),
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .out_q     (out_q),
      .out_valid (out_valid)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: keep the 256 MB region of the PC, add the byte address of the
   // word index inside that region.
   function automatic logic [31:0] model(input logic [25:0] idx, input logic [31:0] p);
      logic [31:0] region;
      region = (p / 32'h1000_0000) * 32'h1000_0000;
      return region + 32'(idx) * 32'd4;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string name);
      check({name, "_out_q"}, out_q, exp_q);
      check({name, "_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
   endtask

   initial begin
      vecs[0] = '{26'd7,         32'hF000_0000, 32'hF000_001C};
      vecs[1] = '{26'h000_5B29,  32'h5000_0000, 32'h5001_6CA4};
      vecs[2] = '{26'd0,         32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{26'h3FF_FFFF,  32'h0FFF_FFFF, 32'h0FFF_FFFC};
      vecs[4] = '{26'd0,         32'hFFFF_FFFF, 32'hF000_0000};
      vecs[5] = '{26'd7,         32'hF0FF_FFFF, 32'hF000_001C};
      vecs[6] = '{26'h200_0001,  32'h8000_0003, 32'h8800_0004};

      // Reset state.
      i = 26'd0; pc = 32'h0; load = 1'b0; rst_n = 1'b0;
      exp_q = 32'h0; exp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("after_release");

      // Directed combinational vectors.
      foreach (vecs[k]) begin
         @(negedge clk);
         i  = vecs[k].idx;
         pc = vecs[k].pcv;
         #1;
         check($sformatf("vec%0d_out", k), out, vecs[k].expected);
      end

      // Registered path: one load, then inputs change with load low.
      @(negedge clk);
      i = 26'd7; pc = 32'hF000_0000; load = 1'b1;
      @(posedge clk);
      #1;
      exp_q = 32'hF000_001C; exp_valid = 1'b1;
      check_regs("load");
      @(negedge clk);
      load = 1'b0; i = 26'h000_5B29; pc = 32'h5000_0000;
      #1;
      check("hold_out", out, 32'h5001_6CA4);
      check_regs("hold_pre");
      @(posedge clk);
      #1;
      check_regs("hold_post");

      // Back-to-back loads overwrite.
      @(negedge clk);
      load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i = 26'h3FF_FFFF; pc = 32'h0FFF_FFFF;
      @(posedge clk);
      #1;
      exp_q = 32'h0FFF_FFFC;
      check_regs("b2b");

      // Asynchronous reset mid-cycle with a load pending.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q = 32'h0; exp_valid = 1'b0;
      check_regs("async_rst");
      i = 26'd7; pc = 32'hF000_0000;
      #1;
      check("rst_out_tracks", out, 32'hF000_001C);
      @(posedge clk);
      #1;
      check_regs("rst_load_dropped");
      @(negedge clk);
      load = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("rst_release_idle");

      // Randomized traffic against the model.
      for (int n = 0; n < 1000; n++) begin
         logic [25:0] ri;
         logic [31:0] rp;
         logic        rl;
         @(negedge clk);
         ri = 26'($urandom);
         rp = $urandom;
         rl = 1'($urandom_range(0, 1));
         i = ri; pc = rp; load = rl;
         #1;
         check("rand_out", out, model(ri, rp));
         @(posedge clk);
         #1;
         if (rl) begin
            exp_q     = model(ri, rp);
            exp_valid = 1'b1;
         end
         check_regs("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_left_pc.md
# shift_left_pc

MIPS jump-target generator for the single-cycle datapath's J/JAL path. It takes the 26-bit instruction index, shifts it left by two, and concatenates it under the upper four bits of the PC to form the 32-bit jump address. The primary output is purely combinational so the PC-select mux can use it in the same cycle. An optional registered copy with a valid flag is provided for pipelined or multi-cycle consumers.

## Interface
Parameters: none; all widths are fixed by the MIPS ISA.

- clk  input  1  system clock; registered stage updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- i  input  26  instruction index field (instr[25:0])
- pc  input  32  current PC; only pc[31:28] is used
- out  output  32  combinational jump target
- load  input  1  capture enable for the registered stage
- out_q  output  32  registered jump target
- out_valid  output  1  out_q holds a captured value

Port declaration order is fixed: i, pc, out first (positional instantiation by existing datapath/benches), then clk, rst_n, load, out_q, out_valid.

## Operation
- out = {pc[31:28], i[25:0], 2'b00}.
- out[1:0] is always 0.
- pc[27:0] is ignored; changing only those bits never changes out.
- No arithmetic, so no carry or overflow. Bits of i cannot spill into out[31:28].
- Registered stage: on a posedge with load=1, out_q <= out and out_valid <= 1.
- On a posedge with load=0, out_q and out_valid hold their values.
- out_valid stays 1 once set, until the next reset.
- The combinational out is independent of clk, rst_n and load; it is valid even while rst_n=0.

## Timing
- out: zero-cycle latency, combinational from i and pc.
- out_q: one-cycle latency from load sampled high; reflects i/pc as sampled at that edge.
- Reset, asynchronous: rst_n falling clears out_q to 32'h0 and out_valid to 0 immediately, without waiting for a clock edge.
- Reset outputs: out_q = 0, out_valid = 0; out is not affected by reset.
- Reset release: registers act on the first posedge where rst_n=1.
- Reset mid-operation: a load pending in the same cycle as rst_n low is discarded.
- Back-to-back loads: each posedge with load=1 overwrites out_q. No handshake or backpressure.
- Inputs changing between edges: out follows immediately; out_q changes only at the edge.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_q=0 and out_valid=0 at once; out still tracks i/pc.
- Upper-PC merge: i=7, pc=32'hF0000000 -> out=32'hF000001C.
- Shift/concatenate: i=23337 (26'h5B29), pc=32'h50000000 -> out=32'h50016CA4. Then i=0, pc=0 -> out=32'h00000000.
- Boundary: i=26'h3FFFFFF, pc=32'h0FFFFFFF -> out=32'h0FFFFFFC (pc low bits ignored, no spill into [31:28]). Then i=0, pc=32'hFFFFFFFF -> out=32'hF0000000.
- Registered path: set i=7, pc=32'hF0000000, load=1 for one posedge -> out_q=32'hF000001C and out_valid=1 after that edge. Change inputs with load=0 -> out changes, out_q holds.
- Randomized: 1000 random i/pc pairs -> out == {pc[31:28], i, 2'b00} every time; out_q matches the value sampled at each load edge.
